// File: rtl/spi_word_rx.sv
// spi_word_rx: SPI mode-0 slave receiver that oversamples SCK/CS_N/MOSI in
// the i_CLK domain, packs MSB-first words and buffers them in a show-ahead FIFO.
//
// Ports:
//   i_CLK, i_RST_N    system clock, asynchronous active-low reset
//   i_SCK, i_CS_N     SPI clock (CPOL=0, CPHA=0) and chip select, asynchronous
//   i_MOSI            SPI data in
//   o_MISO            status readback (SPI_RX_MISO_EN), otherwise constant 0
//   i_WEIGHT_ACK      downstream ready; pops the head word while o_SPI_VALID
//   o_SPI_VALID       FIFO not empty
//   o_SPI_DATA        head-of-FIFO word (0 while empty)
//   i_CLR_FLAGS       one-cycle clear of the sticky flags
//   o_OVERFLOW        sticky: completed word dropped, FIFO full
//   o_FRAME_ERR       sticky: CS_N rose with a partial word
//   o_FIFO_LEVEL      words currently buffered
//
// Optional feature macro: SPI_RX_MISO_EN
//   defined   -> shift out {level, 6'b0, frame_err, overflow, 16'hA55A} on MISO
//   undefined -> o_MISO tied low, no status shifter

module spi_word_rx #(
    parameter int BUS_WIDTH       = 32,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       i_CLK,
    input  logic                       i_RST_N,
    input  logic                       i_SCK,
    input  logic                       i_CS_N,
    input  logic                       i_MOSI,
    output logic                       o_MISO,
    input  logic                       i_WEIGHT_ACK,
    output logic                       o_SPI_VALID,
    output logic [BUS_WIDTH-1:0]       o_SPI_DATA,
    input  logic                       i_CLR_FLAGS,
    output logic                       o_OVERFLOW,
    output logic                       o_FRAME_ERR,
    output logic [FIFO_ADDR_WIDTH:0]   o_FIFO_LEVEL
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam int CW    = $clog2(BUS_WIDTH + 1);
    // Fewer than two flops would not be a synchroniser.
    localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_e;

    // ------------------------------------------------------------------
    // Pin synchronisers and SCK edge detection
    // ------------------------------------------------------------------
    logic [SS-1:0] sck_sync_q;
    logic [SS-1:0] cs_sync_q;
    logic [SS-1:0] mosi_sync_q;
    logic          sck_prev_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SS-2:0], i_SCK};
            cs_sync_q   <= {cs_sync_q[SS-2:0], i_CS_N};
            mosi_sync_q <= {mosi_sync_q[SS-2:0], i_MOSI};
            sck_prev_q  <= sck_s;
        end
    end

    assign sck_s    = sck_sync_q[SS-1];
    assign cs_s     = cs_sync_q[SS-1];
    assign mosi_s   = mosi_sync_q[SS-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    // ------------------------------------------------------------------
    // Receive FSM: bit counter, shift register, push request
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   ferr_set;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!cs_s) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (cs_s) begin
                    // Partial word is simply abandoned; the next word
                    // refills all BUS_WIDTH bits of the shifter.
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    ferr_set = (cnt_q != '0);
                end else if (sck_rise) begin
                    shift_d = {shift_q[BUS_WIDTH-2:0], mosi_s};
                    if (cnt_q == CW'(BUS_WIDTH - 1)) begin
                        // shift_q holds the finished word during the
                        // following cycle, which is when the FIFO writes.
                        cnt_d  = '0;
                        push_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0] level;
    logic                     empty;
    logic                     full;
    logic                     pop;
    logic                     wr_en;
    logic                     ovf_set;

    // Extra pointer MSB distinguishes full from empty.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == (FIFO_ADDR_WIDTH+1)'(DEPTH));
    assign pop     = ~empty & i_WEIGHT_ACK;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en   = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the output is gated while empty.
    always_ff @(posedge i_CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= shift_q;
        end
    end

    assign o_SPI_VALID  = ~empty;
    assign o_SPI_DATA   = empty ? '0 : mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
    assign o_FIFO_LEVEL = level;

    // ------------------------------------------------------------------
    // Sticky flags: a set event beats a simultaneous clear
    // ------------------------------------------------------------------
    logic ovf_q, ovf_d;
    logic ferr_q, ferr_d;

    always_comb begin
        ovf_d  = ovf_set  | (ovf_q  & ~i_CLR_FLAGS);
        ferr_d = ferr_set | (ferr_q & ~i_CLR_FLAGS);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    assign o_OVERFLOW  = ovf_q;
    assign o_FRAME_ERR = ferr_q;

    // ------------------------------------------------------------------
    // MISO status shifter
    // ------------------------------------------------------------------
`ifdef SPI_RX_MISO_EN
    logic [BUS_WIDTH-1:0] miso_q, miso_d;
    logic [CW-1:0]        mcnt_q, mcnt_d;
    logic [31:0]          status_w;
    logic                 sck_fall;
    logic                 enter_recv;

    assign sck_fall   = ~sck_s & sck_prev_q;
    assign enter_recv = (state_q == ST_IDLE) & ~cs_s;
    assign status_w   = {8'(level), 6'b0, ferr_q, ovf_q, 16'hA55A};

    always_comb begin
        miso_d = miso_q;
        mcnt_d = mcnt_q;
        if (enter_recv) begin
            miso_d = BUS_WIDTH'(status_w);
            mcnt_d = '0;
        end else if ((state_q == ST_RECV) && sck_fall) begin
            // Fresh snapshot after each full word so the master can
            // poll status repeatedly inside one frame.
            if (mcnt_q == CW'(BUS_WIDTH - 1)) begin
                miso_d = BUS_WIDTH'(status_w);
                mcnt_d = '0;
            end else begin
                miso_d = {miso_q[BUS_WIDTH-2:0], 1'b0};
                mcnt_d = mcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            miso_q <= '0;
            mcnt_q <= '0;
        end else begin
            miso_q <= miso_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign o_MISO = (state_q == ST_RECV) & miso_q[BUS_WIDTH-1];
`else
    assign o_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// tb_spi_word_rx: randomized self-checking bench for spi_word_rx.
// Drives SPI frames and compares against a queue-based FIFO model.

module tb_spi_word_rx;

    localparam int BW    = 32;
    localparam int AW    = 2;
    localparam int SS    = 2;
    localparam int DEPTH = 4;
    localparam int HALF  = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck   = 1'b0;
    logic          cs_n  = 1'b1;
    logic          mosi  = 1'b0;
    logic          ack   = 1'b0;
    logic          clr   = 1'b0;
    logic          miso;
    logic          valid;
    logic [BW-1:0] data;
    logic          ovf;
    logic          ferr;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;

    logic [31:0] got[$];
    int          vcount   = 0;
    int          ovf_seen = 0;
    logic [31:0] miso_cap = '0;

    spi_word_rx #(
        .BUS_WIDTH      (BW),
        .FIFO_ADDR_WIDTH(AW),
        .SYNC_STAGES    (SS)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_SCK        (sck),
        .i_CS_N       (cs_n),
        .i_MOSI       (mosi),
        .o_MISO       (miso),
        .i_WEIGHT_ACK (ack),
        .o_SPI_VALID  (valid),
        .o_SPI_DATA   (data),
        .i_CLR_FLAGS  (clr),
        .o_OVERFLOW   (ovf),
        .o_FRAME_ERR  (ferr),
        .o_FIFO_LEVEL (level)
    );

    always #5 clk = ~clk;

    // Pop monitor: a word is consumed at the posedge following this sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) vcount++;
            if (valid && ack) got.push_back(data);
            if (ovf) ovf_seen++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input bit pulse_ack);
        mosi = b;
        tick(HALF);
        miso_cap = {miso_cap[30:0], miso};
        sck = 1'b1;
        if (pulse_ack) begin
            // Hold ACK across the edge on which the completed word is written.
            tick(SS + 1);
            ack = 1'b1;
            tick(1);
            ack = 1'b0;
            tick(HALF - SS - 2);
        end else begin
            tick(HALF);
        end
        sck = 1'b0;
    endtask

    task automatic spi_word(input logic [31:0] w, input bit pulse_last);
        for (int i = 0; i < 32; i++) spi_bit(w[31-i], pulse_last && (i == 31));
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_hi();
        tick(HALF);
        cs_n = 1'b1;
        tick(HALF);
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    task automatic drain(input logic [31:0] exp[$], input string nm);
        int gb;
        gb = got.size();
        ack = 1'b1;
        tick(DEPTH + 4);
        ack = 1'b0;
        tick(1);
        checks++;
        if (got.size() - gb !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words expected %0d", nm, got.size() - gb, exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            checks++;
            if (got.size() <= gb + k) begin
                errors++;
                $display("FAIL %s_word%0d: missing, expected %h", nm, k, exp[k]);
            end else if (got[gb+k] !== exp[k]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h expected %h", nm, k, got[gb+k], exp[k]);
            end
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL %s_level: got %0d expected 0", nm, level);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
        checks++; if (data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", data); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", ferr); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", miso); end
    endtask

    task automatic test_single();
        int gb, vb;
        gb = got.size();
        vb = vcount;
        ack = 1'b1;
        cs_lo();
        spi_word(32'h1, 1'b0);
        cs_hi();
        tick(12);
        ack = 1'b0;
        checks++;
        if (got.size() - gb !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d words expected 1", got.size() - gb);
        end else if (got[gb] !== 32'h1) begin
            checks++; errors++;
            $display("FAIL single_data: got %h expected 00000001", got[gb]);
        end
        checks++; if (vcount - vb !== 1) begin errors++; $display("FAIL single_pulse: got %0d cycles expected 1", vcount - vb); end
        checks++; if (level !== '0) begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
        checks++; if ((ovf | ferr) !== 1'b0) begin errors++; $display("FAIL single_flags: got %b%b expected 00", ovf, ferr); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp[$];
        cs_lo();
        for (int k = 0; k < 5; k++) begin
            spi_word(32'h10 + k, 1'b0);
            if (k < DEPTH) exp.push_back(32'h10 + k);
        end
        cs_hi();
        tick(12);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        checks++; if (data !== 32'h10) begin errors++; $display("FAIL ovf_head: got %h expected 00000010", data); end
        drain(exp, "ovf");
        clear_flags();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
    endtask

    task automatic test_frame_err();
        logic [31:0] exp[$];
        logic [31:0] r;
        r = $urandom;
        cs_lo();
        for (int i = 0; i < 17; i++) spi_bit(r[i], 1'b0);
        cs_hi();
        tick(12);
        checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", ferr); end
        checks++; if (level !== '0) begin errors++; $display("FAIL ferr_level: got %0d expected 0", level); end
        cs_lo();
        spi_word(32'hDEAD_BEEF, 1'b0);
        cs_hi();
        tick(12);
        checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ferr_next: got %h expected deadbeef", data); end
        checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", ferr); end
        clear_flags();
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b expected 0", ferr); end
        exp.push_back(32'hDEAD_BEEF);
        drain(exp, "ferr");
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w[$];
        logic [31:0] exp[$];
        int gb;
        for (int k = 0; k < 5; k++) w.push_back($urandom);
        gb = got.size();
        cs_lo();
        for (int k = 0; k < 5; k++) spi_word(w[k], k == 4);
        cs_hi();
        tick(12);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL pp_level: got %0d expected 4", level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %b expected 0", ovf); end
        checks++;
        if (got.size() - gb !== 1 || got[gb] !== w[0]) begin
            errors++;
            $display("FAIL pp_pop: got %0d pops expected 1 of %h", got.size() - gb, w[0]);
        end
        for (int k = 1; k < 5; k++) exp.push_back(w[k]);
        drain(exp, "pp");
    endtask

    task automatic test_flag_race();
        logic [31:0] exp[$];
        logic [31:0] w;
        int ob;
        clr = 1'b1;
        ob = ovf_seen;
        cs_lo();
        for (int k = 0; k < 5; k++) begin
            w = $urandom;
            spi_word(w, 1'b0);
            if (k < DEPTH) exp.push_back(w);
        end
        cs_hi();
        tick(12);
        checks++; if (ovf_seen - ob < 1) begin errors++; $display("FAIL race_set_wins: got %0d flagged cycles expected >=1", ovf_seen - ob); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL race_clr: got %b expected 0", ovf); end
        clr = 1'b0;
        drain(exp, "race");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [31:0] exp[$];
            logic [31:0] w;
            int n;
            bit one_frame;
            n = $urandom_range(1, 6);
            one_frame = $urandom_range(0, 1) == 1;
            if (one_frame) cs_lo();
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (!one_frame) cs_lo();
                spi_word(w, 1'b0);
                if (!one_frame) cs_hi();
                if (exp.size() < DEPTH) exp.push_back(w);
            end
            if (one_frame) cs_hi();
            tick(12);
            checks++;
            if (level !== (AW+1)'(exp.size())) begin
                errors++;
                $display("FAIL rnd%0d_level: got %0d expected %0d", it, level, exp.size());
            end
            checks++;
            if (ovf !== (n > DEPTH)) begin
                errors++;
                $display("FAIL rnd%0d_ovf: got %b expected %b", it, ovf, n > DEPTH);
            end
            drain(exp, "rnd");
            clear_flags();
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] exp[$];
        logic [31:0] r;
        r = $urandom;
        cs_lo();
        spi_word($urandom, 1'b0);
        spi_word($urandom, 1'b0);
        for (int i = 0; i < 20; i++) spi_bit(r[i], 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL mrst_level: got %0d expected 0", level); end
        checks++; if (data !== '0) begin errors++; $display("FAIL mrst_data: got %h expected 0", data); end
        cs_n = 1'b1;
        sck  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        cs_lo();
        spi_word(32'h2, 1'b0);
        cs_hi();
        tick(12);
        checks++; if (data !== 32'h2) begin errors++; $display("FAIL mrst_first: got %h expected 00000002", data); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL mrst_ferr: got %b expected 0", ferr); end
        exp.push_back(32'h2);
        drain(exp, "mrst");
    endtask

    task automatic test_miso();
        logic [31:0] exp[$];
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        cs_lo();
        spi_word(a, 1'b0);
        cs_hi();
        tick(12);
        cs_lo();
        spi_word(b, 1'b0);
        cs_hi();
        tick(12);
`ifdef SPI_RX_MISO_EN
        checks++; if (miso_cap !== 32'h0100_A55A) begin errors++; $display("FAIL miso_status: got %h expected 0100a55a", miso_cap); end
`else
        checks++; if (miso_cap !== 32'h0) begin errors++; $display("FAIL miso_tied: got %h expected 00000000", miso_cap); end
`endif
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL miso_idle: got %b expected 0", miso); end
        exp.push_back(a);
        exp.push_back(b);
        drain(exp, "miso");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_frame_err();
        test_full_push_pop();
        test_flag_race();
        test_random();
        test_reset_midframe();
        test_miso();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
